// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage with PC, single-outstanding imem handshake and IF/ID register.
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   stall_i, flush_i            hazard-unit hold / branch-unit squash of IF/ID
//   redirect_i, redirect_pc_i   taken branch/jump and its target (bits [1:0] forced to 0)
//   imem_req_o, imem_addr_o     fetch request and word-aligned address
//   imem_gnt_i                  request accepted this cycle
//   imem_rvalid_i, imem_rdata_i read response
//   id_valid_o, id_instr_o      IF/ID live flag and instruction
//   id_pc4_o                    IF/ID PC+4 of that instruction
//   id_imm16_o                  id_instr_o[15:0] for the decode sign extender
//   fetch_cnt_o                 loaded-instruction counter, only when IF_PERF_CNT_EN is defined
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc4_o,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] fetch_cnt_o,
`endif
    output logic [15:0] id_imm16_o
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_req_pc4, r_hold_instr, r_hold_pc4, r_id_instr, r_id_pc4;
    logic        r_kill, r_id_valid;
    logic [31:0] w_pc4;
    logic        w_can_load, w_gnt, w_resp, w_live, w_load, w_capture, w_from_hold;
    assign w_pc4       = r_pc + 32'd4;
    assign w_can_load  = !stall_i && !flush_i;
    assign w_gnt       = r_state == S_FETCH && imem_gnt_i;
    assign w_resp      = r_state == S_WAIT && imem_rvalid_i;
    // a response is usable only if it was not killed earlier and no redirect arrives with it
    assign w_live      = w_resp && !r_kill && !redirect_i;
    assign w_from_hold = r_state == S_HOLD;
    assign w_load      = (w_live || (w_from_hold && !redirect_i)) && w_can_load;
    assign w_capture   = w_live && !w_can_load;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: if (imem_gnt_i) w_next = S_WAIT;
            S_WAIT:  if (imem_rvalid_i) w_next = w_capture ? S_HOLD : S_FETCH;
            S_HOLD:  if (redirect_i || w_can_load) w_next = S_FETCH;
            default: w_next = S_FETCH;
        endcase
    end
    always_comb begin
        imem_req_o  = rst_n && r_state == S_FETCH;
        imem_addr_o = r_pc;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_req_pc4    <= '0;
            r_kill       <= 1'b0;
            r_hold_instr <= '0;
            r_hold_pc4   <= '0;
            r_id_valid   <= 1'b0;
            r_id_instr   <= '0;
            r_id_pc4     <= '0;
        end else begin
            if (redirect_i) r_pc <= {redirect_pc_i[31:2], 2'b00};
            else if (w_gnt) r_pc <= w_pc4;
            if (w_gnt) r_req_pc4 <= w_pc4;
            // a redirect in the grant cycle or while waiting poisons the outstanding response
            if (w_gnt) r_kill <= redirect_i;
            else if (w_resp) r_kill <= 1'b0;
            else if (r_state == S_WAIT && redirect_i) r_kill <= 1'b1;
            if (w_capture) begin
                r_hold_instr <= imem_rdata_i;
                r_hold_pc4   <= r_req_pc4;
            end
            if (flush_i) begin
                r_id_valid <= 1'b0;
                r_id_instr <= '0;
            end else if (!stall_i) begin
                r_id_valid <= w_load;
                r_id_instr <= w_load ? (w_from_hold ? r_hold_instr : imem_rdata_i) : '0;
                if (w_load) r_id_pc4 <= w_from_hold ? r_hold_pc4 : r_req_pc4;
            end
        end
    end
`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_fetch_cnt <= '0;
        else if (w_load) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
    assign fetch_cnt_o = r_fetch_cnt;
`endif
    assign id_valid_o = r_id_valid;
    assign id_instr_o = r_id_instr;
    assign id_pc4_o   = r_id_pc4;
    assign id_imm16_o = r_id_instr[15:0];
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and drives a single-outstanding-request instruction-memory handshake.
- Holds the IF/ID pipeline register that feeds the decode stage.
- id_imm16_o feeds the decode-stage sign extender directly; id_instr_o and id_pc4_o feed the control unit and the branch-target adder.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hazard unit: hold IF/ID contents
flush_i  in  1  branch unit: squash IF/ID contents
redirect_i  in  1  branch/jump taken; load redirect_pc_i into PC
redirect_pc_i  in  32  target PC; bits [1:0] ignored, forced to 0
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address (word aligned)
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  read data valid
imem_rdata_i  in  32  read data
id_valid_o  out  1  IF/ID holds a live instruction
id_instr_o  out  32  IF/ID instruction
id_pc4_o  out  32  IF/ID PC+4 of that instruction
id_imm16_o  out  16  id_instr_o[15:0], combinational

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, state=FETCH, kill_q=0, hold buffer empty.
  - id_valid_o=0, id_instr_o=0, id_pc4_o=0.
  - imem_req_o=0 while rst_n=0.
- FSM states: FETCH, WAIT, HOLD.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc_q.
  - On imem_gnt_i: latch req_pc4=pc_q+4, set pc_q<=pc_q+4, go to WAIT.
- WAIT:
  - imem_req_o=0. At most one request is ever outstanding.
  - On imem_rvalid_i with kill_q=1: discard the data, clear kill_q, go to FETCH.
  - On imem_rvalid_i with kill_q=0:
    - If IF/ID can load (stall_i=0 and flush_i=0): load {imem_rdata_i, req_pc4}, id_valid_o<=1, go to FETCH.
    - Otherwise: capture data into the hold buffer, go to HOLD.
- HOLD:
  - imem_req_o=0.
  - When stall_i=0 and flush_i=0: move the buffer into IF/ID, id_valid_o<=1, go to FETCH.
- Redirect (priority over normal PC update in every state):
  - pc_q<=redirect_pc_i & ~3.
  - FETCH with imem_gnt_i in the same cycle: the granted request is marked killed (kill_q<=1), go to WAIT.
  - WAIT: kill_q<=1. If imem_rvalid_i arrives in the same cycle, discard it, clear kill_q, go to FETCH.
  - HOLD: drop the buffer, go to FETCH.
- IF/ID register priority: flush_i > stall_i > load > bubble.
  - flush_i: id_valid_o<=0, id_instr_o<=0 (NOP); id_pc4_o unchanged.
  - stall_i: all IF/ID outputs hold.
  - No new instruction and no stall: id_valid_o<=0, id_instr_o<=0.
- Latency: instruction appears in IF/ID on the clock edge where imem_rvalid_i is sampled (zero-wait memory gives 1 instruction per 2 cycles).
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Reset mid-request: the FSM returns to FETCH; a late imem_rvalid_i after reset release while in FETCH is ignored.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds output port fetch_cnt_o [31:0], reset to 0.
  - Increments by 1 on each cycle IF/ID loads a valid instruction.
  - Killed or discarded responses are not counted.
  - Wraps at 2^32.
- Undefined: no port, no counter logic.

Test Plan:
- Reset release, RESET_PC=0, gnt/rvalid always 1, rdata=addr → IF/ID shows (0x0,pc4 0x4), (0x4,0x8), (0x8,0xC) on alternate cycles; id_imm16_o = rdata[15:0].
- stall_i=1 for 3 cycles while rvalid returns 0x8C220004 → state HOLD, IF/ID unchanged; stall drop → IF/ID=0x8C220004, id_imm16_o=16'h0004.
- redirect_i=1, redirect_pc_i=0x0000_1003 in WAIT with rvalid same cycle → data discarded, next imem_addr_o=0x0000_1000.
- redirect_i in WAIT, rvalid 2 cycles later → that response dropped (kill_q), id_valid_o stays 0, next fetch at redirect target.
- flush_i and stall_i both 1 → id_valid_o=0, id_instr_o=0.
- RESET_PC=32'hFFFF_FFFC → second fetch address 0x0000_0000; with IF_PERF_CNT_EN, fetch_cnt_o=2 after two loads.
